// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light monitor: light codes, monitor
// states, violation causes and the default phase lengths.
package traffic_pkg;

  // Light codes as they appear on the 2-bit signal bus
  localparam logic [1:0] SIG_ERR    = 2'b00;
  localparam logic [1:0] SIG_RED    = 2'b01;
  localparam logic [1:0] SIG_GREEN  = 2'b10;
  localparam logic [1:0] SIG_YELLOW = 2'b11;

  // Monitor states; both yellows share one wire code, so Y1/Y2 exist only here
  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_RED   = 3'd1,
    ST_Y1    = 3'd2,
    ST_GREEN = 3'd3,
    ST_Y2    = 3'd4
  } mon_state_t;

  // Violation causes reported on err_code
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CODE  = 2'b01;
  localparam logic [1:0] ERR_SHORT = 2'b10;
  localparam logic [1:0] ERR_LONG  = 2'b11;

  // Default phase lengths in cycles and phase counter width
  localparam int DEF_RED_LEN   = 10;
  localparam int DEF_Y1_LEN    = 1;
  localparam int DEF_GREEN_LEN = 9;
  localparam int DEF_Y2_LEN    = 2;
  localparam int DEF_CW        = 5;

endpackage

// File: rtl/tl_phase_counter.sv
// Per-phase counter pair: cnt counts samples seen in the current phase,
// remaining counts down the samples still owed after the present one.
module tl_phase_counter
  import traffic_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] load_rem,
  input  logic          step,
  input  logic [CW-1:0] len,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] remaining,
  output logic          at_len
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rem_q, rem_d;

  // Clear wins over load, load wins over step; a load marks the first sample
  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    if (clear) begin
      cnt_d = '0;
      rem_d = '0;
    end else if (load) begin
      cnt_d = CW'(1);
      rem_d = load_rem;
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
      rem_d = rem_q - CW'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      rem_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
    end
  end

  assign cnt       = cnt_q;
  assign remaining = rem_q;
  assign at_len    = (cnt_q == len);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic-light bus: locks onto the
// red -> yellow -> green -> yellow -> red sequence, verifies each phase
// length and successor, exports a countdown and keeps statistics.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int RED_LEN   = DEF_RED_LEN,
  parameter int Y1_LEN    = DEF_Y1_LEN,
  parameter int GREEN_LEN = DEF_GREEN_LEN,
  parameter int Y2_LEN    = DEF_Y2_LEN,
  parameter int CW        = DEF_CW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    signal,
  output logic          locked,
  output logic [1:0]    phase,
  output logic [CW-1:0] remaining,
  output logic          err_pulse,
  output logic [1:0]    err_code,
  output logic [7:0]    err_cnt,
  output logic [7:0]    cycle_cnt
);

  localparam logic [CW-1:0] RED_L    = CW'(RED_LEN);
  localparam logic [CW-1:0] Y1_L     = CW'(Y1_LEN);
  localparam logic [CW-1:0] GREEN_L  = CW'(GREEN_LEN);
  localparam logic [CW-1:0] Y2_L     = CW'(Y2_LEN);
  localparam logic [CW-1:0] RED_M1   = CW'(RED_LEN - 1);
  localparam logic [CW-1:0] Y1_M1    = CW'(Y1_LEN - 1);
  localparam logic [CW-1:0] GREEN_M1 = CW'(GREEN_LEN - 1);
  localparam logic [CW-1:0] Y2_M1    = CW'(Y2_LEN - 1);

  mon_state_t    state_q, state_d;
  logic [1:0]    prev_q, prev_d;
  logic          locked_q, locked_d;
  logic [1:0]    phase_q, phase_d;
  logic          err_pulse_q, err_pulse_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [7:0]    cycle_cnt_q, cycle_cnt_d;

  logic [1:0]    cur_code;
  logic [CW-1:0] cur_len;
  logic [1:0]    succ_code;
  mon_state_t    succ_state;
  logic [CW-1:0] succ_rem;

  logic          ctr_clear;
  logic          ctr_load;
  logic [CW-1:0] ctr_load_rem;
  logic          ctr_step;
  logic [CW-1:0] cnt;
  logic          at_len;

  tl_phase_counter #(
    .CW (CW)
  ) u_phase_counter (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (ctr_clear),
    .load      (ctr_load),
    .load_rem  (ctr_load_rem),
    .step      (ctr_step),
    .len       (cur_len),
    .cnt       (cnt),
    .remaining (remaining),
    .at_len    (at_len)
  );

  // Decode the tracked phase: its wire code, its length, and who follows it
  always_comb begin
    cur_code   = SIG_ERR;
    cur_len    = '0;
    succ_code  = SIG_ERR;
    succ_state = ST_HUNT;
    succ_rem   = '0;
    case (state_q)
      ST_RED: begin
        cur_code   = SIG_RED;
        cur_len    = RED_L;
        succ_code  = SIG_YELLOW;
        succ_state = ST_Y1;
        succ_rem   = Y1_M1;
      end
      ST_Y1: begin
        cur_code   = SIG_YELLOW;
        cur_len    = Y1_L;
        succ_code  = SIG_GREEN;
        succ_state = ST_GREEN;
        succ_rem   = GREEN_M1;
      end
      ST_GREEN: begin
        cur_code   = SIG_GREEN;
        cur_len    = GREEN_L;
        succ_code  = SIG_YELLOW;
        succ_state = ST_Y2;
        succ_rem   = Y2_M1;
      end
      ST_Y2: begin
        cur_code   = SIG_YELLOW;
        cur_len    = Y2_L;
        succ_code  = SIG_RED;
        succ_state = ST_RED;
        succ_rem   = RED_M1;
      end
      default: ;
    endcase
  end

  // Sequence tracking: stay, advance to the successor, or flag a violation
  always_comb begin
    state_d      = state_q;
    prev_d       = signal;
    locked_d     = locked_q;
    phase_d      = phase_q;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    err_cnt_d    = err_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    ctr_clear    = 1'b0;
    ctr_load     = 1'b0;
    ctr_load_rem = '0;
    ctr_step     = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (signal == SIG_RED && prev_q != SIG_RED) begin
          state_d      = ST_RED;
          ctr_load     = 1'b1;
          ctr_load_rem = RED_M1;
          locked_d     = 1'b1;
          phase_d      = SIG_RED;
        end
      end
      ST_RED, ST_Y1, ST_GREEN, ST_Y2: begin
        if (signal == cur_code && cnt < cur_len) begin
          ctr_step = 1'b1;
        end else if (at_len && signal == succ_code) begin
          state_d      = succ_state;
          ctr_load     = 1'b1;
          ctr_load_rem = succ_rem;
          phase_d      = signal;
          if (state_q == ST_Y2) begin
            cycle_cnt_d = cycle_cnt_q + 8'd1;
          end
        end else begin
          state_d     = ST_HUNT;
          ctr_clear   = 1'b1;
          locked_d    = 1'b0;
          phase_d     = SIG_ERR;
          err_pulse_d = 1'b1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          if (signal == SIG_ERR) begin
            err_code_d = ERR_CODE;
          end else if (signal != cur_code && cnt < cur_len) begin
            err_code_d = ERR_SHORT;
          end else begin
            err_code_d = ERR_LONG;
          end
        end
      end
      default: begin
        state_d   = ST_HUNT;
        ctr_clear = 1'b1;
        locked_d  = 1'b0;
        phase_d   = SIG_ERR;
      end
    endcase
  end

  // State, history sample and statistics registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_HUNT;
      prev_q      <= SIG_ERR;
      locked_q    <= 1'b0;
      phase_q     <= SIG_ERR;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_cnt_q   <= 8'd0;
      cycle_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      locked_q    <= locked_d;
      phase_q     <= phase_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign phase     = phase_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_cnt   = err_cnt_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed, table-driven bench for traffic_light_monitor with the default
// lengths (red 10, yellow 1, green 9, yellow 2).
module tb_traffic_light_monitor;

  typedef struct {
    logic [1:0] sig;
    logic       lk;
    logic [1:0] ph;
    logic [4:0] rem;
    logic       pl;
    logic [1:0] ec;
    logic [7:0] ecnt;
    logic [7:0] ccnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [1:0] signal = 2'b00;
  logic       locked;
  logic [1:0] phase;
  logic [4:0] remaining;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] err_cnt;
  logic [7:0] cycle_cnt;

  int   n_compared = 0;
  int   n_mismatched = 0;
  vec_t vecs[$];

  traffic_light_monitor dut (
    .clk       (clk),
    .rstn      (rstn),
    .signal    (signal),
    .locked    (locked),
    .phase     (phase),
    .remaining (remaining),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .err_cnt   (err_cnt),
    .cycle_cnt (cycle_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Drive one sample on the falling edge, then settle just after the rising edge
  task automatic applyStimulus(input logic [1:0] s);
    @(negedge clk);
    signal = s;
    @(posedge clk);
    #1;
  endtask

  // Single comparison with failure report
  task automatic checkOutput(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  // Compare every output against one expected record
  task automatic checkVector(input string nm, input int idx, input vec_t v);
    checkOutput({nm, ".locked"}, idx, 8'(locked), 8'(v.lk));
    checkOutput({nm, ".phase"}, idx, 8'(phase), 8'(v.ph));
    checkOutput({nm, ".remaining"}, idx, 8'(remaining), 8'(v.rem));
    checkOutput({nm, ".err_pulse"}, idx, 8'(err_pulse), 8'(v.pl));
    checkOutput({nm, ".err_code"}, idx, 8'(err_code), 8'(v.ec));
    checkOutput({nm, ".err_cnt"}, idx, err_cnt, v.ecnt);
    checkOutput({nm, ".cycle_cnt"}, idx, cycle_cnt, v.ccnt);
  endtask

  task automatic addVec(input logic [1:0] sig, input logic lk, input logic [1:0] ph, input int rem,
                        input logic pl, input logic [1:0] ec, input int ecnt, input int ccnt);
    vec_t v;
    v.sig  = sig;
    v.lk   = lk;
    v.ph   = ph;
    v.rem  = 5'(rem);
    v.pl   = pl;
    v.ec   = ec;
    v.ecnt = 8'(ecnt);
    v.ccnt = 8'(ccnt);
    vecs.push_back(v);
  endtask

  // n locked samples of one phase, remaining counting down from first_rem
  task automatic addRun(input logic [1:0] sig, input int first_rem, input int n,
                        input logic [1:0] ec, input int ecnt, input int ccnt);
    for (int i = 0; i < n; i++) addVec(sig, 1'b1, sig, first_rem - i, 1'b0, ec, ecnt, ccnt);
  endtask

  task automatic addHunt(input logic [1:0] sig, input logic [1:0] ec, input int ecnt, input int ccnt);
    addVec(sig, 1'b0, 2'b00, 0, 1'b0, ec, ecnt, ccnt);
  endtask

  task automatic addViol(input logic [1:0] sig, input logic [1:0] ec, input int ecnt, input int ccnt);
    addVec(sig, 1'b0, 2'b00, 0, 1'b1, ec, ecnt, ccnt);
  endtask

  task automatic runTable(input string nm);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].sig);
      checkVector(nm, i, vecs[i]);
    end
    vecs.delete();
  endtask

  task automatic checkZero(input string nm);
    vec_t z;
    z.sig = 2'b00; z.lk = 1'b0; z.ph = 2'b00; z.rem = 5'd0;
    z.pl = 1'b0; z.ec = 2'b00; z.ecnt = 8'd0; z.ccnt = 8'd0;
    checkVector(nm, 0, z);
  endtask

  task automatic doReset(input string nm);
    @(negedge clk);
    rstn   = 1'b0;
    signal = 2'b00;
    #1;
    checkZero(nm);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Guard against a stuck run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;

    // Legal sequence: one idle sample, three periods, then the third return to red
    doReset("reset_legal");
    addHunt(2'b00, 2'b00, 0, 0);
    for (int p = 0; p < 3; p++) begin
      addRun(2'b01, 9, 10, 2'b00, 0, p);
      addRun(2'b11, 0, 1, 2'b00, 0, p);
      addRun(2'b10, 8, 9, 2'b00, 0, p);
      addRun(2'b11, 1, 2, 2'b00, 0, p);
    end
    addRun(2'b01, 9, 1, 2'b00, 0, 3);
    runTable("legal");

    // Green cut short after 8 samples, then relock on a fresh red edge
    doReset("reset_short");
    addHunt(2'b00, 2'b00, 0, 0);
    addRun(2'b01, 9, 10, 2'b00, 0, 0);
    addRun(2'b11, 0, 1, 2'b00, 0, 0);
    addRun(2'b10, 8, 8, 2'b00, 0, 0);
    addViol(2'b11, 2'b10, 1, 0);
    addHunt(2'b11, 2'b10, 1, 0);
    addRun(2'b01, 9, 3, 2'b10, 1, 0);
    runTable("short");

    // Red overstays; the violating red sample and its successor do not relock
    doReset("reset_over");
    addHunt(2'b00, 2'b00, 0, 0);
    addRun(2'b01, 9, 10, 2'b00, 0, 0);
    addViol(2'b01, 2'b11, 1, 0);
    addHunt(2'b01, 2'b11, 1, 0);
    addHunt(2'b01, 2'b11, 1, 0);
    runTable("overstay");

    // Error-code mix accumulating err_cnt up to 5, ending mid-green
    doReset("reset_codes");
    addHunt(2'b00, 2'b00, 0, 0);
    addRun(2'b01, 9, 10, 2'b00, 0, 0);
    addRun(2'b11, 0, 1, 2'b00, 0, 0);
    addRun(2'b10, 8, 4, 2'b00, 0, 0);
    addViol(2'b00, 2'b01, 1, 0);
    addRun(2'b01, 9, 10, 2'b01, 1, 0);
    addViol(2'b10, 2'b11, 2, 0);
    addRun(2'b01, 9, 10, 2'b11, 2, 0);
    addRun(2'b11, 0, 1, 2'b11, 2, 0);
    addRun(2'b10, 8, 3, 2'b11, 2, 0);
    addViol(2'b01, 2'b10, 3, 0);
    addHunt(2'b01, 2'b10, 3, 0);
    addHunt(2'b00, 2'b10, 3, 0);
    addRun(2'b01, 9, 10, 2'b10, 3, 0);
    addRun(2'b11, 0, 1, 2'b10, 3, 0);
    addViol(2'b11, 2'b11, 4, 0);
    addHunt(2'b00, 2'b11, 4, 0);
    addRun(2'b01, 9, 10, 2'b11, 4, 0);
    addRun(2'b11, 0, 1, 2'b11, 4, 0);
    addRun(2'b10, 8, 9, 2'b11, 4, 0);
    addRun(2'b11, 1, 2, 2'b11, 4, 0);
    addViol(2'b10, 2'b11, 5, 0);
    addHunt(2'b00, 2'b11, 5, 0);
    addRun(2'b01, 9, 10, 2'b11, 5, 0);
    addRun(2'b11, 0, 1, 2'b11, 5, 0);
    addRun(2'b10, 8, 4, 2'b11, 5, 0);
    runTable("codes");

    // Asynchronous reset in the middle of green clears everything at once
    #2;
    rstn   = 1'b0;
    signal = 2'b01;
    #1;
    checkZero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Constant red after release: one lock, one overstay, then no relock
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      v.sig = 2'b01;
      v.ccnt = 8'd0;
      if (k < 10) begin
        v.lk = 1'b1; v.ph = 2'b01; v.rem = 5'(9 - k); v.pl = 1'b0; v.ec = 2'b00; v.ecnt = 8'd0;
      end else if (k == 10) begin
        v.lk = 1'b0; v.ph = 2'b00; v.rem = 5'd0; v.pl = 1'b1; v.ec = 2'b11; v.ecnt = 8'd1;
      end else begin
        v.lk = 1'b0; v.ph = 2'b00; v.rem = 5'd0; v.pl = 1'b0; v.ec = 2'b11; v.ecnt = 8'd1;
      end
      checkVector("const_red", k, v);
    end

    // 300 forced violations: lock on red, then an error code
    doReset("reset_sat");
    for (int k = 0; k < 300; k++) begin
      applyStimulus(2'b01);
      applyStimulus(2'b00);
      checkOutput("sat.err_pulse", k, 8'(err_pulse), 8'd1);
      checkOutput("sat.err_cnt", k, err_cnt, (k + 1 > 255) ? 8'd255 : 8'(k + 1));
    end
    applyStimulus(2'b00);
    checkOutput("sat.hold", 0, err_cnt, 8'd255);
    checkOutput("sat.pulse_off", 0, 8'(err_pulse), 8'd0);

    // 258 legal periods so cycle_cnt wraps past 255
    doReset("reset_wrap");
    applyStimulus(2'b00);
    for (int p = 0; p < 258; p++) begin
      for (int i = 0; i < 10; i++) begin
        applyStimulus(2'b01);
        if (i == 0) begin
          checkOutput("wrap.cycle_cnt", p, cycle_cnt, 8'(p % 256));
          checkOutput("wrap.locked", p, 8'(locked), 8'd1);
        end
      end
      applyStimulus(2'b11);
      repeat (9) applyStimulus(2'b10);
      repeat (2) applyStimulus(2'b11);
    end
    applyStimulus(2'b01);
    checkOutput("wrap.final", 0, cycle_cnt, 8'd2);
    checkOutput("wrap.err_cnt", 0, err_cnt, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive receiver/checker for the 2-bit traffic-light `signal` bus: 2'b00 = error, 2'b01 = red, 2'b10 = green, 2'b11 = yellow. It sits on the controller output and does four things:
- Synchronises to the phase sequence red → yellow1 → green → yellow2 → red.
- Checks every phase duration and successor against programmed lengths.
- Exports a per-phase countdown for a display.
- Counts completed periods and violations.

It never drives the light.

## Interface
- `RED_LEN`, 10, red phase length in cycles
- `Y1_LEN`, 1, yellow length between red and green
- `GREEN_LEN`, 9, green phase length
- `Y2_LEN`, 2, yellow length between green and red
- `CW`, 5, phase counter width; every `*_LEN` must satisfy 1 ≤ LEN ≤ 2^CW−1
- `clk` in 1: single clock, all logic on posedge
- `rstn` in 1: reset, asynchronous and active-low
- `signal` in 2: light code from the controller, sampled every posedge
- `locked` out 1: high while tracking a legal sequence
- `phase` out 2: code of the currently tracked phase; 2'b00 when not locked
- `remaining` out CW: cycles left in the current phase after the present one
- `err_pulse` out 1: one-cycle pulse on a violation
- `err_code` out 2: cause of the last violation; holds until the next violation
- `err_cnt` out 8: violation count, saturates at 255
- `cycle_cnt` out 8: completed full periods, wraps 255→0

## Operation
- States:
  - `HUNT`, `RED`, `Y1`, `GREEN`, `Y2`.
  - Internal `cnt` (CW bits) counts consecutive samples of the current phase.
  - Internal `prev` holds the previous sample.
- Reset: state `HUNT`, `prev` = 2'b00, and every output is 0.
- `HUNT`:
  - If `signal` == 01 and `prev` != 01, go to `RED`. Set `cnt` = 1, `remaining` = RED_LEN−1, `locked` = 1, `phase` = 01.
  - Otherwise stay in `HUNT`.
- Tracked state with phase code C, length L, sample s:
  - If s == C and `cnt` < L: `cnt`++, `remaining`−−.
  - Else if `cnt` == L and s == successor code: enter the successor state. Set `cnt` = 1, `remaining` = L_next−1, `phase` = s.
  - Successors: `RED`→`Y1` (11), `Y1`→`GREEN` (10), `GREEN`→`Y2` (11), `Y2`→`RED` (01).
  - The `Y2`→`RED` transition increments `cycle_cnt`.
  - Otherwise it is a violation:
    - Go to `HUNT`, with `locked` = 0, `phase` = 00, `remaining` = 0.
    - Set `err_pulse` = 1 and `err_cnt` += 1 (saturating).
    - `err_code` is chosen by the first matching rule below.
- `err_code` rules, in priority order:
  - 2'b01: s == 00.
  - 2'b10: s != C and `cnt` < L (phase ended early).
  - 2'b11: overstay (s == C at `cnt` == L) or wrong successor.
- Yellow is ambiguous on the wire (both yellows use 11). `Y1` versus `Y2` is decided only by the state.
- A violation cycle never relocks in the same cycle, even when s == 01. Relock requires a later 01 whose `prev` is not 01.
- `prev` <= `signal` every cycle, in all states.

## Timing
- All outputs are registered. They reflect the sample taken at the same posedge, so latency is 1 cycle from `signal`.
- `err_pulse` is high for exactly one cycle per violation. Back-to-back violations are impossible, because `HUNT` produces none.
- `remaining` reaches 0 on the last legal cycle of a phase. A legal transition reloads it in that same cycle.
- `rstn` asserted mid-phase clears everything asynchronously, including `err_cnt` and `cycle_cnt`. After release, tracking resumes only at a fresh red edge.
- Reference period with default parameters: 22 cycles.

## Structure
- Package `traffic_pkg` holds:
  - Light codes `SIG_ERR`/`SIG_RED`/`SIG_GREEN`/`SIG_YELLOW`.
  - The state enum `mon_state_t`.
  - Error codes `ERR_NONE`/`ERR_CODE`/`ERR_SHORT`/`ERR_LONG`.
  - The default lengths.
- Sub-module `tl_phase_counter`:
  - Loadable CW-bit up-count `cnt` plus down-count `remaining`.
  - Inputs: load value, increment/decrement enable, clear.
  - Outputs: `cnt`, `remaining`, `at_len` flag.
- The FSM, `prev`, and the statistics counters live in the top level.

## Test plan
- Legal sequence: reset, 1 cycle of 00, then 3 full periods (10×01, 1×11, 9×10, 2×11).
  - Required: `locked` = 1 from the first red sample.
  - Required: `remaining` counts 9..0 in red.
  - Required: `cycle_cnt` = 3 at the third return to red; `err_cnt` = 0, and `err_pulse` never high.
- Short phase: green held for 8 cycles, then 11.
  - Required: `err_pulse` for one cycle, `err_code` = 10, `locked` = 0.
  - Required: relock on the next red edge after a non-red sample.
- Overstay: red held for 11 cycles.
  - Required: `err_code` = 11 on the 11th sample, `err_cnt` = 1.
- Error code and wrong successor:
  - 00 injected mid-green: `err_code` = 01.
  - Red directly after red-length expiry as green: `err_code` = 11.
- Reset mid-green with `err_cnt` = 5.
  - Required: all outputs 0 immediately.
  - Required: constant 01 after release locks once only.
- Saturation: 300 forced violations.
  - Required: `err_cnt` holds at 255.
  - Required: `cycle_cnt` wraps correctly across 256 legal periods.
